// File: rtl/mult_acc_cell.sv
// mult_acc_cell
// Pipelined signed/unsigned multiplier with an optional multiply-accumulate
// mode, a sticky accumulate overflow flag, valid-tagged stages and a global
// stall.
//
// Ports:
//   clk        rising-edge clock for all state
//   reset      synchronous active-high reset; overrides en
//   en         advance the pipeline; 0 freezes every register
//   in_valid   operation present on the inputs (sampled when en=1)
//   dataa      operand A, WIDTH_A bits
//   datab      operand B, WIDTH_B bits
//   signa      1 = dataa is two's complement
//   signb      1 = datab is two's complement
//   mac        0 = plain multiply, 1 = accumulate product
//   acc_clr    with mac=1, accumulate onto zero and clear the overflow flag
//   result     product (mul) or new accumulator value (mac), ACC_WIDTH bits
//   out_valid  result carries a newly completed operation
//   overflow   sticky accumulate overflow
//
// Latency: an op accepted at edge N is presented at edge N+PIPE_STAGES-1.
// Stage 1 registers the inputs, stages 2..PIPE_STAGES-1 delay the product and
// tags, and the last stage is the output/accumulator register.

module mult_acc_cell #(
  parameter int WIDTH_A     = 32,
  parameter int WIDTH_B     = 32,
  parameter int ACC_WIDTH   = 64,
  parameter int PIPE_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic [WIDTH_A-1:0]   dataa,
  input  logic [WIDTH_B-1:0]   datab,
  input  logic                 signa,
  input  logic                 signb,
  input  logic                 mac,
  input  logic                 acc_clr,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 out_valid,
  output logic                 overflow
);

  localparam int DLY = PIPE_STAGES - 2;

  typedef struct packed {
    logic                 valid;
    logic                 mac;
    logic                 clr;
    logic                 sgn;
    logic [ACC_WIDTH-1:0] prod;
  } tag_t;

  logic [WIDTH_A-1:0]   dataa_q;
  logic [WIDTH_B-1:0]   datab_q;
  logic                 signa_q;
  logic                 signb_q;
  logic                 mac_q;
  logic                 clr_q;
  logic                 valid_q;

  logic signed [ACC_WIDTH-1:0] a_ext;
  logic signed [ACC_WIDTH-1:0] b_ext;
  logic signed [ACC_WIDTH-1:0] prod;

  tag_t s1_tag;
  tag_t last_tag;

  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] addend;
  logic [ACC_WIDTH:0]   sum_ext;
  logic [ACC_WIDTH-1:0] sum;
  logic                 ovf_now;

  // Stage 1: input register.
  always_ff @(posedge clk) begin
    if (reset) begin
      dataa_q <= '0;
      datab_q <= '0;
      signa_q <= 1'b0;
      signb_q <= 1'b0;
      mac_q   <= 1'b0;
      clr_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (en) begin
      dataa_q <= dataa;
      datab_q <= datab;
      signa_q <= signa;
      signb_q <= signb;
      mac_q   <= mac;
      clr_q   <= acc_clr;
      valid_q <= in_valid;
    end
  end

  // Each operand gets one extra bit (its sign bit or zero) and is then
  // sign-extended to ACC_WIDTH. The exact (WIDTH_A+1)x(WIDTH_B+1) product
  // always fits in ACC_WIDTH, so multiplying at ACC_WIDTH is exact; the
  // constant upper bits let synthesis trim the multiplier back down.
  always_comb begin
    a_ext  = ACC_WIDTH'($signed({signa_q & dataa_q[WIDTH_A-1], dataa_q}));
    b_ext  = ACC_WIDTH'($signed({signb_q & datab_q[WIDTH_B-1], datab_q}));
    prod   = a_ext * b_ext;
    s1_tag = '{valid: valid_q, mac: mac_q, clr: clr_q,
               sgn: signa_q | signb_q, prod: prod};
  end

  // Stages 2..PIPE_STAGES-1: pure delay of product and tags.
  if (DLY > 0) begin : g_dly
    tag_t dly_q [DLY];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < DLY; i++) dly_q[i] <= '0;
      end else if (en) begin
        dly_q[0] <= s1_tag;
        for (int i = 1; i < DLY; i++) dly_q[i] <= dly_q[i-1];
      end
    end

    assign last_tag = dly_q[DLY-1];
  end else begin : g_nodly
    assign last_tag = s1_tag;
  end

  // Accumulate adder. The extra top bit of sum_ext is the unsigned carry;
  // signed overflow is the classic same-sign-in, different-sign-out test.
  always_comb begin
    addend  = last_tag.clr ? '0 : acc_q;
    sum_ext = {1'b0, addend} + {1'b0, last_tag.prod};
    sum     = sum_ext[ACC_WIDTH-1:0];
    if (last_tag.sgn) begin
      ovf_now = (addend[ACC_WIDTH-1] == last_tag.prod[ACC_WIDTH-1]) &&
                (sum[ACC_WIDTH-1] != addend[ACC_WIDTH-1]);
    end else begin
      ovf_now = sum_ext[ACC_WIDTH];
    end
  end

  // Output stage. Tags are only acted on for valid ops; acc_clr drops the
  // old sticky flag before the fresh 0+product sum is evaluated.
  always_ff @(posedge clk) begin
    if (reset) begin
      result    <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      acc_q     <= '0;
    end else if (en) begin
      out_valid <= last_tag.valid;
      if (last_tag.valid) begin
        if (last_tag.mac) begin
          acc_q    <= sum;
          result   <= sum;
          overflow <= (last_tag.clr ? 1'b0 : overflow) | ovf_now;
        end else begin
          result <= last_tag.prod;
        end
      end
    end
  end

endmodule

// File: doc/mult_acc_cell.md
Name: mult_acc_cell

Overview:
Parametrised successor to the CPU 32x32 multiply cell. It is a pipelined signed/unsigned multiplier with per-operation signedness, and its latency is set by parameter. It adds a multiply-accumulate mode with sticky overflow, a valid-tagged pipeline, and a global stall. It sits beside the CPU datapath and DSP/ADC processing paths, inferred to DSP blocks.

Parameters:
WIDTH_A, 32, operand A width (2..64)
WIDTH_B, 32, operand B width (2..64)
ACC_WIDTH, 64, result/accumulator width; must be >= WIDTH_A+WIDTH_B
PIPE_STAGES, 2, total latency in cycles from accept to out_valid (2..6)

Ports:
clk  in  1  clock; all logic rising-edge
reset  in  1  synchronous, active-high reset
en  in  1  pipeline advance; 0 freezes every stage, including the accumulator
in_valid  in  1  operation present on inputs; sampled only when en=1
dataa  in  WIDTH_A  operand A
datab  in  WIDTH_B  operand B
signa  in  1  1 = dataa is two's complement
signb  in  1  1 = datab is two's complement
mac  in  1  0 = plain multiply, 1 = accumulate product into accumulator
acc_clr  in  1  with mac=1: accumulate onto zero instead of the running value
result  out  ACC_WIDTH  product (mul) or accumulator value (mac)
out_valid  out  1  result holds a new operation this cycle
overflow  out  1  sticky accumulate overflow

Behaviour:
- Reset (sync, active-high): all stage registers, valid bits, result, accumulator, out_valid and overflow go to 0. Reset takes priority over en. Operations in flight are discarded.
- Stage 1 (input register): when en=1, capture dataa, datab, signa, signb, mac, acc_clr and in_valid.
- Product: (WIDTH_A+1)x(WIDTH_B+1) signed multiply. Each operand is extended by its sign bit if its sign flag is 1, otherwise by zero. The product is sign-extended to ACC_WIDTH and is exact; it never truncates.
- Stages 2..PIPE_STAGES-1 are pure delay of the product and tags. The final stage is the output register.
- Latency: with en held at 1, an op accepted at edge N appears at edge N+PIPE_STAGES-1. out_valid is high for exactly one en=1 cycle per op.
- Bubbles (in_valid=0) propagate with valid=0. result holds its last value while out_valid=0.
- en=0: no register changes, out_valid is held, and no op is lost or duplicated.
- mul mode: result = extended product. The accumulator is unaffected.
- mac mode: sum = (acc_clr ? 0 : acc) + product, computed modulo 2^ACC_WIDTH. Both acc and result are set to sum.
- Overflow in mac mode:
  - For a signed op (signa|signb), overflow is set if the operands share a sign bit and the sum's sign differs.
  - For an unsigned op, overflow is set on carry out of bit ACC_WIDTH-1.
  - The flag stays set until reset or a mac op with acc_clr=1. That op clears it, then it is re-evaluated on the 0+product sum, which cannot overflow.
- Back-to-back mac ops accumulate every cycle with no hazard bubble; the accumulator update is single-cycle in the output stage.
- A mac op with in_valid=0 does nothing: tags are only acted on when valid.
- Mixing mul and mac ops is legal. mul ops leave acc and overflow untouched.

Test Plan:
- Reset/latency: PIPE_STAGES=3, reset 2 cycles, then unsigned 7x6 (mac=0) at edge 0 -> out_valid and result=42 at edge 2. Before that, result=0, out_valid=0, overflow=0.
- Signedness: signa=1, signb=0, dataa=32'hFFFFFFFF, datab=2 -> result=64'hFFFFFFFFFFFFFFFE. Same operands with both signs 0 -> 64'h00000001FFFFFFFE.
- Streaming and stall: 10 consecutive ops with en toggling 1,0,1,1,0... -> exactly 10 out_valid pulses, results in order, none duplicated.
- MAC chain: acc_clr=1 op 3x4, then 5x5 and 2x(-1) signed -> results 12, 37, 35 on consecutive valid cycles. A following mul op 2x2 -> 4, then a mac 1x1 -> 36.
- Overflow: ACC_WIDTH=64, unsigned mac of 32'hFFFFFFFF^2 repeated until a carry out of bit 63 -> overflow set and sticky through further ops. A mac op with acc_clr=1 clears it.
- Reset mid-operation: assert reset with 2 ops in flight -> no out_valid is produced for them, and the accumulator is zero for the next mac op.
